// File: rtl/jk_counter_ctrl_if.sv
// ----------------------------------------------------------------------------
// jk_counter_ctrl_if
// Control bundle between the system, the jk_counter_ctrl sequencer and the
// JK flip-flop bank it drives.
//   start/stop/load : command strobes from the system
//   up_dn           : count direction (1 = up)
//   load_val        : parallel load / reload value
//   term_val        : terminal count
//   q               : fed-back outputs of the JK bank
//   j/k             : J/K inputs to the JK bank
//   busy/tc/done    : status back to the system
// ----------------------------------------------------------------------------
interface jk_counter_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             stop;
    logic             load;
    logic             up_dn;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] term_val;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             busy;
    logic             tc;
    logic             done;

    // System / bench side
    modport master (
        output start, stop, load, up_dn, load_val, term_val,
        input  q, j, k, busy, tc, done
    );

    // Sequencer side
    modport slave (
        input  start, stop, load, up_dn, load_val, term_val, q,
        output j, k, busy, tc, done
    );
endinterface

// File: rtl/jk_counter_ctrl.sv
// ----------------------------------------------------------------------------
// jk_counter_ctrl
// Sequencer for a WIDTH-bit synchronous counter built from JK flip-flops.
// Drives per-bit J/K from the fed-back q to load, count up/down, stop and
// detect terminal count, with optional auto-reload on terminal count.
// Ports:
//   clk   : counter clock, rising edge
//   reset : asynchronous, active-high
//   bus   : jk_counter_ctrl_if.slave (commands, q in, j/k/busy/tc/done out)
// ----------------------------------------------------------------------------
module jk_counter_ctrl #(
    parameter int WIDTH       = 4,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    jk_counter_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state, w_state_nxt;
    logic             r_dir, w_dir_nxt;
    logic [WIDTH-1:0] r_ld, w_ld_nxt;
    logic             r_done, w_done_nxt;

    logic [WIDTH-1:0] w_tog;
    logic [WIDTH-1:0] w_j, w_k;
    logic             w_busy, w_tc, w_eq;

    assign w_eq = (bus.q == bus.term_val);

    // Per-bit toggle enables: bit i toggles when all lower bits are 1 (up)
    // or all lower bits are 0 (down); bit 0 always toggles.
    always_comb begin : toggle_chain
        logic v_carry;
        v_carry = 1'b1;
        w_tog   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_tog[i] = v_carry;
            v_carry  = v_carry & (r_dir ? bus.q[i] : ~bus.q[i]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_dir   <= 1'b1;
            r_ld    <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_dir   <= w_dir_nxt;
            r_ld    <= w_ld_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_dir_nxt   = r_dir;
        w_ld_nxt    = r_ld;
        w_done_nxt  = 1'b0;
        w_j         = '0;
        w_k         = '0;
        w_busy      = 1'b0;
        w_tc        = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                // load wins over start
                if (bus.load) begin
                    w_ld_nxt    = bus.load_val;
                    w_state_nxt = S_LOAD;
                end else if (bus.start) begin
                    w_dir_nxt   = bus.up_dn;
                    w_ld_nxt    = bus.load_val;
                    w_state_nxt = S_RUN;
                end
            end
            S_LOAD: begin
                w_busy      = 1'b1;
                w_j         = r_ld;
                w_k         = ~r_ld;
                w_state_nxt = S_IDLE;
            end
            S_RUN: begin
                w_busy = 1'b1;
                w_tc   = w_eq;
                if (bus.stop) begin
                    // abort: hold q, no done even on terminal count
                    w_state_nxt = S_IDLE;
                end else if (w_eq && !AUTO_RELOAD) begin
                    w_state_nxt = S_DONE;
                    w_done_nxt  = 1'b1;
                end else if (w_eq) begin
                    // reload from the value latched at start, keep running
                    w_j        = r_ld;
                    w_k        = ~r_ld;
                    w_done_nxt = 1'b1;
                end else begin
                    w_j = w_tog;
                    w_k = w_tog;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign bus.j    = w_j;
    assign bus.k    = w_k;
    assign bus.busy = w_busy;
    assign bus.tc   = w_tc;
    assign bus.done = r_done;

endmodule

// File: doc/jk_counter_ctrl.md
Name: jk_counter_ctrl

Overview:
Sequencing controller for the WIDTH-bit synchronous counter built from a bank of JK flip-flops. It drives per-bit J/K inputs from the flops' fed-back q. It implements load, run up/down, stop and terminal-count detection, with optional auto-reload. It sits between the system control interface and the JK bank. The JK bank shares this block's clk and reset.

Parameters:
WIDTH, 4, counter width (number of JK flip-flops driven)
AUTO_RELOAD, 0, 1 = on terminal count reload from stored load value and keep running; 0 = stop

Ports:
clk  input  1  counter clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  begin counting (sampled in IDLE)
stop  input  1  abort counting (sampled in RUN)
load  input  1  request parallel load of load_val (sampled in IDLE)
up_dn  input  1  direction, 1 = up, 0 = down; latched on start
load_val  input  WIDTH  parallel load value; latched on load and on start
term_val  input  WIDTH  terminal count compared against q
q  input  WIDTH  fed-back outputs of the JK bank
j  output  WIDTH  J inputs to the JK bank
k  output  WIDTH  K inputs to the JK bank
busy  output  1  high in LOAD and RUN
tc  output  1  combinational; high in RUN when q == term_val
done  output  1  one-cycle registered pulse after a terminal-count edge

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on port reset.
- Reset values, immediate and asynchronous:
  - state = IDLE
  - dir_r = 1
  - ld_r = 0
  - done = 0
  - j = k = 0 (combinational from state), busy = 0, tc = 0
- States: IDLE, LOAD, RUN, DONE. State is registered; j/k/busy/tc decode combinationally from state, q and latches.
- IDLE:
  - j = k = 0 (hold).
  - load=1: ld_r <= load_val, go LOAD. load has priority over start.
  - else start=1: dir_r <= up_dn, ld_r <= load_val, go RUN.
  - stop is ignored.
- LOAD:
  - j = ld_r, k = ~ld_r. After that edge, q == ld_r.
  - Next state is IDLE unconditionally; one cycle only.
- RUN, toggle equations:
  - Up: j[i] = k[i] = &q[i-1:0].
  - Down: j[i] = k[i] = &~q[i-1:0].
  - Bit 0 always toggles.
- RUN, wrap-around: up wraps 2^WIDTH-1 -> 0; down wraps 0 -> 2^WIDTH-1. term_val is always eventually reached.
- RUN, tc = (q == term_val).
- RUN, priority (highest first):
  - stop=1: j = k = 0, go IDLE. No done, even if tc=1.
  - tc=1 and AUTO_RELOAD=0: j = k = 0 (q holds at term_val), go DONE.
  - tc=1 and AUTO_RELOAD=1: j = ld_r, k = ~ld_r, stay RUN, done <= 1.
  - otherwise: apply toggle equations.
- Direction: up_dn changes during RUN are ignored; dir_r holds the value latched at start.
- start while RUN is ignored. Load requests are honoured only in IDLE.
- DONE: j = k = 0, done = 1 for exactly this cycle, next state IDLE.
- Edge case, term_val equal to the start value: if q == term_val in the first RUN cycle, tc fires immediately. Zero increments occur; stop or reload acts on that edge.
- done is registered; clear it on every cycle it is not being set.
- Reset mid-operation: any state goes to IDLE at once with j = k = 0; no done pulse. The JK bank is cleared by the same reset, so q = 0.

Test Plan:
- Reset then load: reset, then load=1 with load_val=4'hA for one cycle -> busy=1 for one cycle, j=4'hA, k=4'h5; q=4'hA afterwards; back in IDLE with j=k=0.
- Up count to terminal: q=0, term_val=4'h5, up_dn=1, pulse start, AUTO_RELOAD=0 -> q steps 1,2,3,4,5; tc=1 at q=5; q holds 5; done=1 for one cycle; then IDLE with busy=0.
- Down count with wrap: load 4'h1, term_val=4'hE, up_dn=0, start -> q steps 0, F, E; tc at E; done pulses; up_dn toggled mid-run has no effect.
- Stop overrides terminal count: up from 0 with term_val=4'h3; assert stop in the cycle q==3 -> go IDLE, done stays 0, q holds 3.
- Auto-reload (AUTO_RELOAD=1): load_val=4'h2, term_val=4'h4, up, start -> q sequence 2,3,4,2,3,4…; done pulses one cycle after each reload edge; busy stays 1.
- Async reset mid-run: counting up at q=4'h7, assert reset between clock edges -> j=k=0, busy=0, done=0 immediately; q=0; state IDLE after release.
